// File: rtl/paddle_encoder.sv
// Quadrature encoder + button front end for one pong paddle: sync, optional debounce, x4 decode, saturated position.
// Optional debounce filters are compiled in with `define PADDLE_DEBOUNCE_EN.
module paddle_encoder #(
    parameter logic [10:0] SCR_H      = 11'd20,
    parameter logic [10:0] PAD_H      = 11'd4,
    parameter logic [10:0] STEP       = 11'd1,
    parameter int unsigned DEB_CYCLES = 8,
    parameter logic [10:0] POS_INIT   = (SCR_H - PAD_H) / 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENC_QA,
    input  logic        ENC_QB,
    input  logic        BUTTON,
    output logic [10:0] POS,
    output logic        MOVE,
    output logic        DIR,
    output logic        ERR,
    output logic        BTN_PRESS
);

    localparam int unsigned PW = 11;
    localparam int unsigned AW = 12;
    localparam logic [AW-1:0] POS_MAX = AW'(SCR_H) - AW'(PAD_H);

    if (DEB_CYCLES == 0 || PAD_H == 11'd0 || PAD_H > SCR_H) begin : g_param_bad
        $error("paddle_encoder: illegal parameter set");
    end

    // bit 2 = button, bit 1 = channel A, bit 0 = channel B
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] filt;

    assign raw = {BUTTON, ENC_QA, ENC_QB};

    // 2-FF synchronizers, idle-high so reset exit is transition-free
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef PADDLE_DEBOUNCE_EN
    localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    logic [CW-1:0] deb_cnt [3];

    // accept a new level after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            filt <= 3'b111;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    logic [1:0]    prev_ab;
    logic          btn_prev;
    logic          fwd;
    logic          rev;
    logic          ill;
    logic [AW-1:0] pos_sum;
    logic [AW-1:0] pos_up;
    logic [AW-1:0] pos_dn;
    logic [PW-1:0] pos_nxt;
    logic          dir_nxt;
    logic          move_nxt;
    logic          err_nxt;
    logic          btn_nxt;

    // Gray-code transition classification on {prev, cur}
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        ill = 1'b0;
        case ({prev_ab, filt[1:0]})
            4'b1101, 4'b0100, 4'b0010, 4'b1011: fwd = 1'b1;
            4'b1110, 4'b1000, 4'b0001, 4'b0111: rev = 1'b1;
            4'b1100, 4'b0011, 4'b0110, 4'b1001: ill = 1'b1;
            default: ;
        endcase
    end

    assign pos_sum = {1'b0, POS} + {1'b0, STEP};
    assign pos_up  = (pos_sum > POS_MAX) ? POS_MAX : pos_sum;
    assign pos_dn  = (POS < STEP) ? '0 : {1'b0, POS - STEP};

    always_comb begin
        pos_nxt = POS;
        dir_nxt = DIR;
        err_nxt = 1'b0;
        if (fwd) begin
            pos_nxt = PW'(pos_up);
            dir_nxt = 1'b1;
        end else if (rev) begin
            pos_nxt = PW'(pos_dn);
            dir_nxt = 1'b0;
        end else if (ill) begin
            err_nxt = 1'b1;
        end
        move_nxt = (pos_nxt != POS);
        btn_nxt  = btn_prev & ~filt[2];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_ab   <= 2'b11;
            btn_prev  <= 1'b1;
            POS       <= POS_INIT;
            DIR       <= 1'b0;
            MOVE      <= 1'b0;
            ERR       <= 1'b0;
            BTN_PRESS <= 1'b0;
        end else begin
            prev_ab   <= filt[1:0];
            btn_prev  <= filt[2];
            POS       <= pos_nxt;
            DIR       <= dir_nxt;
            MOVE      <= move_nxt;
            ERR       <= err_nxt;
            BTN_PRESS <= btn_nxt;
        end
    end

endmodule

// File: tb/tb_paddle_encoder.sv
// Self-checking bench for paddle_encoder: vector table, reference model + event scoreboard, corner sequences.
module tb_paddle_encoder;

`ifdef PADDLE_DEBOUNCE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 2;
`endif
    localparam int PMAX = 16;
    localparam int HOLD = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        qa = 1'b1;
    logic        qb = 1'b1;
    logic        btn = 1'b1;
    logic [10:0] pos;
    logic        move, dir, err, btn_press;

    typedef struct packed {
        logic [10:0] pos;
        logic        dir;
        logic        move;
        logic        err;
    } ev_t;

    typedef struct {
        logic [1:0] ab;
        int         exp_pos;
        logic       exp_dir;
    } vec_t;

    ev_t  sb[$];
    vec_t fwd_tab[4];

    int n_cmp = 0;
    int n_bad = 0;
    int move_cnt = 0;
    int err_cnt = 0;
    int btn_cnt = 0;

    int         m_pos;
    logic       m_dir;
    logic [1:0] m_prev;

    paddle_encoder #(
        .SCR_H(11'd20), .PAD_H(11'd4), .STEP(11'd1), .DEB_CYCLES(8)
    ) dut (
        .CLK(clk), .RST(rst_n), .ENC_QA(qa), .ENC_QB(qb), .BUTTON(btn),
        .POS(pos), .MOVE(move), .DIR(dir), .ERR(err), .BTN_PRESS(btn_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b11:   return 2'b01;
            2'b01:   return 2'b00;
            2'b00:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // reference model: classify the new pin pair and queue any expected pulse
    task automatic model_step(input logic [1:0] ab);
        int   old = m_pos;
        logic e = 1'b0;
        if (ab == m_prev) return;
        if (ab == fwd_next(m_prev)) begin
            m_pos = (m_pos + 1 > PMAX) ? PMAX : m_pos + 1;
            m_dir = 1'b1;
        end else if (m_prev == fwd_next(ab)) begin
            m_pos = (m_pos < 1) ? 0 : m_pos - 1;
            m_dir = 1'b0;
        end else begin
            e = 1'b1;
        end
        m_prev = ab;
        if (e || m_pos != old)
            sb.push_back('{pos: 11'(m_pos), dir: m_dir, move: (m_pos != old), err: e});
    endtask

    // scoreboard: every observed pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (move) move_cnt++;
            if (err) err_cnt++;
            if (btn_press) btn_cnt++;
            if (move || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {30'd0, move, err}, 0);
                end else begin
                    ev_t x;
                    x = sb.pop_front();
                    chk("ev_pos", int'(pos), int'(x.pos));
                    chk("ev_flags", int'({dir, move, err}), int'({x.dir, x.move, x.err}));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [1:0] ab, input int hold);
        @(negedge clk);
        {qa, qb} = ab;
        model_step(ab);
        wait_cyc(hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {qa, qb} = 2'b11;
        btn = 1'b1;
        sb.delete();
        m_pos = 8; m_dir = 1'b0; m_prev = 2'b11;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    initial begin
        int lat;
        int m0, e0, b0;
        logic [1:0] seq;

        fwd_tab[0] = '{2'b01, 9, 1'b1};
        fwd_tab[1] = '{2'b00, 10, 1'b1};
        fwd_tab[2] = '{2'b10, 11, 1'b1};
        fwd_tab[3] = '{2'b11, 12, 1'b1};
        m_pos = 8; m_dir = 1'b0; m_prev = 2'b11;

        // reset: outputs hold their reset values, then idle pins give no pulses
        wait_cyc(10);
        chk("rst_pos", int'(pos), 8);
        chk("rst_dir", int'(dir), 0);
        chk("rst_pulses", int'({move, err, btn_press}), 0);
        rst_n = 1'b1;
        wait_cyc(100);
        chk("idle_pos", int'(pos), 8);
        chk("idle_pulses", move_cnt + err_cnt + btn_cnt, 0);

        // forward table; first entry also measures latency from pin edge
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                @(negedge clk);
                {qa, qb} = fwd_tab[i].ab;
                model_step(fwd_tab[i].ab);
                lat = -1;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (move) begin lat = k; break; end
                end
                chk("latency", lat, LAT);
                wait_cyc(50);
            end else begin
                step(fwd_tab[i].ab, 50);
            end
            chk("fwd_pos", int'(pos), fwd_tab[i].exp_pos);
            chk("fwd_dir", int'(dir), int'(fwd_tab[i].exp_dir));
        end
        chk("fwd_moves", move_cnt, 4);

        // saturation up then down
        do_reset();
        m0 = move_cnt;
        seq = 2'b11;
        for (int i = 0; i < 12; i++) begin
            seq = fwd_next(seq);
            step(seq, HOLD);
        end
        chk("sat_hi_moves", move_cnt - m0, 8);
        chk("sat_hi_pos", int'(pos), 16);
        chk("sat_hi_dir", int'(dir), 1);
        m0 = move_cnt;
        for (int i = 0; i < 20; i++) begin
            case (seq)
                2'b11:   seq = 2'b10;
                2'b10:   seq = 2'b00;
                2'b00:   seq = 2'b01;
                default: seq = 2'b11;
            endcase
            step(seq, HOLD);
        end
        chk("sat_lo_moves", move_cnt - m0, 16);
        chk("sat_lo_pos", int'(pos), 0);
        chk("sat_lo_dir", int'(dir), 0);

        // illegal double-change, both directions
        e0 = err_cnt;
        m0 = move_cnt;
        step(2'b00, HOLD);
        chk("ill_err", err_cnt - e0, 1);
        chk("ill_pos", int'(pos), 0);
        step(2'b11, HOLD);
        chk("ill_err2", err_cnt - e0, 2);
        chk("ill_moves", move_cnt - m0, 0);

`ifdef PADDLE_DEBOUNCE_EN
        // short glitch on A is filtered out
        m0 = move_cnt; e0 = err_cnt;
        @(negedge clk);
        qa = 1'b0;
        wait_cyc(5);
        qa = 1'b1;
        wait_cyc(30);
        chk("glitch_moves", move_cnt - m0, 0);
        chk("glitch_errs", err_cnt - e0, 0);
`endif

        // button: one press pulse per hold, none on release
        b0 = btn_cnt;
        @(negedge clk);
        btn = 1'b0;
        wait_cyc(200);
        chk("btn_hold", btn_cnt - b0, 1);
        btn = 1'b1;
        wait_cyc(50);
        chk("btn_release", btn_cnt - b0, 1);

        // encoder and button in the same cycle
        b0 = btn_cnt; m0 = move_cnt;
        @(negedge clk);
        btn = 1'b0;
        {qa, qb} = 2'b01;
        model_step(2'b01);
        wait_cyc(HOLD);
        chk("simul_btn", btn_cnt - b0, 1);
        chk("simul_move", move_cnt - m0, 1);
        btn = 1'b1;
        wait_cyc(HOLD);

        // reset mid-operation with a transition in flight
        do_reset();
        seq = 2'b11;
        for (int i = 0; i < 6; i++) begin
            seq = fwd_next(seq);
            step(seq, HOLD);
        end
        chk("mid_pos", int'(pos), 14);
        @(negedge clk);
        {qa, qb} = fwd_next(seq);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_pos", int'(pos), 8);
        chk("async_dir", int'(dir), 0);
        chk("async_move", int'(move), 0);
        {qa, qb} = 2'b11;
        m_pos = 8; m_dir = 1'b0; m_prev = 2'b11;
        wait_cyc(5);
        m0 = move_cnt;
        rst_n = 1'b1;
        wait_cyc(100);
        chk("post_rst_moves", move_cnt - m0, 0);
        chk("post_rst_pos", int'(pos), 8);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
